// File: rtl/fp_multiply_seq.sv
// Sequential floating-point multiplier: shift-add mantissa product (one multiplier
// bit per cycle), bias-corrected exponent, normalise, optional round, ovf/unf flags.
module fp_multiply_seq #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 6,
    parameter int BIAS  = 15,
    parameter int ROUND = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sign_a,
    input  logic             sign_b,
    input  logic [EXP_W-1:0] exp_a,
    input  logic [EXP_W-1:0] exp_b,
    input  logic [MAN_W-1:0] man_a,
    input  logic [MAN_W-1:0] man_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sign_out,
    output logic [EXP_W-1:0] exp_out,
    output logic [MAN_W-1:0] man_out,
    output logic             ovf,
    output logic             unf
);

    localparam int P_W   = 2 * MAN_W;
    localparam int CNT_W = $clog2(MAN_W + 1);
    // Two spare bits above the signed EXP_W+1 range so the normalise and round
    // increments can never wrap before the overflow compare.
    localparam int E_W   = EXP_W + 3;

    localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(MAN_W - 1);
    localparam logic signed [E_W-1:0] E_ONE    = E_W'(1);
    localparam logic signed [E_W-1:0] E_MAX    = E_W'((1 << EXP_W) - 1);
    localparam logic signed [E_W-1:0] E_BIAS   = E_W'(BIAS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic             sign_r;
    logic             zero_r;
    logic [EXP_W-1:0] exp_a_r, exp_b_r;
    logic [P_W-1:0]   mcand;
    logic [MAN_W-1:0] mplier;
    logic [P_W-1:0]   acc;
    logic [CNT_W-1:0] cnt;

    // NOTE: every reg uses async active-low reset so an abort mid-operation
    // returns the block to a clean IDLE without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: defaults first so no path through the case leaves state_nxt unassigned
    // (which would infer a latch).
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = MUL;
            end
            MUL:  if (cnt == LAST_CNT) state_nxt = NORM;
            NORM: state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Normalise, round and range-check the finished product.
    logic signed [E_W-1:0] e_sum, e_fin;
    logic [MAN_W-1:0]      man_n, man_fin;
    logic [MAN_W:0]        man_inc;
    logic                  guard;
    logic                  res_ovf, res_unf;
    logic [EXP_W-1:0]      res_exp;
    logic [MAN_W-1:0]      res_man;

    always_comb begin
        e_sum = $signed(E_W'(exp_a_r)) + $signed(E_W'(exp_b_r)) - E_BIAS;
        if (acc[P_W-1]) begin
            man_n = acc[P_W-1 -: MAN_W];
            guard = acc[MAN_W-1];
            e_fin = e_sum + E_ONE;
        end else begin
            man_n = acc[P_W-2 -: MAN_W];
            guard = acc[MAN_W-2];
            e_fin = e_sum;
        end

        man_inc = {1'b0, man_n} + (MAN_W + 1)'(1);
        man_fin = man_n;
        if (ROUND != 0 && guard) begin
            if (man_inc[MAN_W]) begin
                man_fin = {1'b1, {(MAN_W - 1){1'b0}}};
                e_fin   = e_fin + E_ONE;
            end else begin
                man_fin = man_inc[MAN_W-1:0];
            end
        end

        res_ovf = 1'b0;
        res_unf = 1'b0;
        res_exp = e_fin[EXP_W-1:0];
        res_man = man_fin;
        if (zero_r) begin
            res_exp = '0;
            res_man = '0;
        end else if (e_fin > E_MAX) begin
            res_ovf = 1'b1;
            res_exp = '1;
            res_man = '1;
        end else if (e_fin < E_ONE) begin
            res_unf = 1'b1;
            res_exp = '0;
            res_man = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_r    <= 1'b0;
            zero_r    <= 1'b0;
            exp_a_r   <= '0;
            exp_b_r   <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            sign_out  <= 1'b0;
            exp_out   <= '0;
            man_out   <= '0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (in_valid) begin
                    sign_r  <= sign_a ^ sign_b;
                    zero_r  <= (man_a == '0) || (man_b == '0);
                    exp_a_r <= exp_a;
                    exp_b_r <= exp_b;
                    mcand   <= {{MAN_W{1'b0}}, man_a};
                    mplier  <= man_b;
                    acc     <= '0;
                    cnt     <= '0;
                end
                MUL: begin
                    // mcand walks left and mplier right, so bit 0 is always man_b[cnt].
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                end
                NORM: begin
                    out_valid <= 1'b1;
                    sign_out  <= sign_r;
                    exp_out   <= res_exp;
                    man_out   <= res_man;
                    ovf       <= res_ovf;
                    unf       <= res_unf;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    ovf       <= 1'b0;
                    unf       <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_multiply_seq.sv
// Directed bench for fp_multiply_seq: a truncating and a rounding instance share
// stimulus; each scenario task checks its own hand-computed results.
module tb_fp_multiply_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic       sign_a = 1'b0, sign_b = 1'b0;
    logic [4:0] exp_a = '0, exp_b = '0;
    logic [5:0] man_a = '0, man_b = '0;

    logic       in_ready0, out_valid0, sign_out0, ovf0, unf0;
    logic [4:0] exp_out0;
    logic [5:0] man_out0;
    logic       in_ready1, out_valid1, sign_out1, ovf1, unf1;
    logic [4:0] exp_out1;
    logic [5:0] man_out1;

    logic [13:0] res0, res1;
    assign res0 = {sign_out0, exp_out0, man_out0, ovf0, unf0};
    assign res1 = {sign_out1, exp_out1, man_out1, ovf1, unf1};

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    fp_multiply_seq #(.EXP_W(5), .MAN_W(6), .BIAS(15), .ROUND(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .sign_a(sign_a), .sign_b(sign_b), .exp_a(exp_a), .exp_b(exp_b),
        .man_a(man_a), .man_b(man_b), .out_valid(out_valid0), .out_ready(out_ready),
        .sign_out(sign_out0), .exp_out(exp_out0), .man_out(man_out0),
        .ovf(ovf0), .unf(unf0)
    );

    fp_multiply_seq #(.EXP_W(5), .MAN_W(6), .BIAS(15), .ROUND(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .sign_a(sign_a), .sign_b(sign_b), .exp_a(exp_a), .exp_b(exp_b),
        .man_a(man_a), .man_b(man_b), .out_valid(out_valid1), .out_ready(out_ready),
        .sign_out(sign_out1), .exp_out(exp_out1), .man_out(man_out1),
        .ovf(ovf1), .unf(unf1)
    );

    function automatic logic [13:0] pk(input logic s, input logic [4:0] e,
                                       input logic [5:0] m, input logic o, input logic u);
        return {s, e, m, o, u};
    endfunction

    // Present one operand pair for a single accept edge, scramble the inputs
    // afterwards, and count edges until out_valid (bounded).
    task automatic run_op(input logic sa, input logic [4:0] ea, input logic [5:0] ma,
                          input logic sb, input logic [4:0] eb, input logic [5:0] mb,
                          output int lat);
        @(negedge clk);
        sign_a = sa; exp_a = ea; man_a = ma;
        sign_b = sb; exp_b = eb; man_b = mb;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        sign_a = ~sa; exp_a = ~ea; man_a = ~ma;
        sign_b = ~sb; exp_b = ~eb; man_b = ~mb;
        lat = 0;
        while (out_valid0 !== 1'b1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic drain();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        compared++;
        if ({in_ready0, out_valid0, res0} !== {1'b1, 1'b0, 14'd0}) begin
            mismatched++;
            $display("FAIL reset_state0: got %h expected %h", {in_ready0, out_valid0, res0}, {1'b1, 1'b0, 14'd0});
        end
        compared++;
        if ({in_ready1, out_valid1, res1} !== {1'b1, 1'b0, 14'd0}) begin
            mismatched++;
            $display("FAIL reset_state1: got %h expected %h", {in_ready1, out_valid1, res1}, {1'b1, 1'b0, 14'd0});
        end
    endtask

    task automatic test_basic();
        int lat;
        logic [13:0] exp_r;
        exp_r = pk(1'b1, 5'd16, 6'b100100, 1'b0, 1'b0);
        run_op(1'b0, 5'd15, 6'b110000, 1'b1, 5'd15, 6'b110000, lat);
        compared++;
        if (lat !== 7) begin
            mismatched++;
            $display("FAIL basic_latency: got %0d expected 7", lat);
        end
        compared++;
        if (res0 !== exp_r) begin
            mismatched++;
            $display("FAIL basic_result0: got %h expected %h", res0, exp_r);
        end
        compared++;
        if (res1 !== exp_r) begin
            mismatched++;
            $display("FAIL basic_result1: got %h expected %h", res1, exp_r);
        end
        drain();
        compared++;
        if ({out_valid0, in_ready0, ovf0, unf0} !== 4'b0100) begin
            mismatched++;
            $display("FAIL basic_release: got %b expected 0100", {out_valid0, in_ready0, ovf0, unf0});
        end
    endtask

    task automatic test_rounding();
        int lat;
        // 49*49 = 100101100001: guard bit set, no carry.
        run_op(1'b0, 5'd15, 6'b110001, 1'b0, 5'd15, 6'b110001, lat);
        compared++;
        if (res0 !== pk(1'b0, 5'd16, 6'b100101, 1'b0, 1'b0)) begin
            mismatched++;
            $display("FAIL round_trunc: got %h expected %h", res0, pk(1'b0, 5'd16, 6'b100101, 1'b0, 1'b0));
        end
        compared++;
        if (res1 !== pk(1'b0, 5'd16, 6'b100110, 1'b0, 1'b0)) begin
            mismatched++;
            $display("FAIL round_up: got %h expected %h", res1, pk(1'b0, 5'd16, 6'b100110, 1'b0, 1'b0));
        end
        drain();
        // 40*51 = 011111111000: mantissa all ones with guard set, round carries out.
        run_op(1'b0, 5'd15, 6'b101000, 1'b0, 5'd15, 6'b110011, lat);
        compared++;
        if (res0 !== pk(1'b0, 5'd15, 6'b111111, 1'b0, 1'b0)) begin
            mismatched++;
            $display("FAIL carry_trunc: got %h expected %h", res0, pk(1'b0, 5'd15, 6'b111111, 1'b0, 1'b0));
        end
        compared++;
        if (res1 !== pk(1'b0, 5'd16, 6'b100000, 1'b0, 1'b0)) begin
            mismatched++;
            $display("FAIL carry_round: got %h expected %h", res1, pk(1'b0, 5'd16, 6'b100000, 1'b0, 1'b0));
        end
        drain();
    endtask

    task automatic test_ovf_unf();
        int lat;
        run_op(1'b0, 5'd30, 6'b100000, 1'b0, 5'd30, 6'b100000, lat);
        compared++;
        if ({res0, res1} !== {2{pk(1'b0, 5'd31, 6'b111111, 1'b1, 1'b0)}}) begin
            mismatched++;
            $display("FAIL overflow: got %h/%h expected %h", res0, res1, pk(1'b0, 5'd31, 6'b111111, 1'b1, 1'b0));
        end
        drain();
        run_op(1'b0, 5'd1, 6'b100000, 1'b0, 5'd1, 6'b100000, lat);
        compared++;
        if ({res0, res1} !== {2{pk(1'b0, 5'd0, 6'b000000, 1'b0, 1'b1)}}) begin
            mismatched++;
            $display("FAIL underflow: got %h/%h expected %h", res0, res1, pk(1'b0, 5'd0, 6'b000000, 1'b0, 1'b1));
        end
        drain();
        // e = 23+23-15 = 31 exactly: in range truncated, overflows only after rounding carry.
        run_op(1'b0, 5'd23, 6'b101000, 1'b0, 5'd23, 6'b110011, lat);
        compared++;
        if (res0 !== pk(1'b0, 5'd31, 6'b111111, 1'b0, 1'b0)) begin
            mismatched++;
            $display("FAIL emax_trunc: got %h expected %h", res0, pk(1'b0, 5'd31, 6'b111111, 1'b0, 1'b0));
        end
        compared++;
        if (res1 !== pk(1'b0, 5'd31, 6'b111111, 1'b1, 1'b0)) begin
            mismatched++;
            $display("FAIL emax_round_ovf: got %h expected %h", res1, pk(1'b0, 5'd31, 6'b111111, 1'b1, 1'b0));
        end
        drain();
        // e = 8+8-15 = 1: smallest legal exponent.
        run_op(1'b1, 5'd8, 6'b100000, 1'b0, 5'd8, 6'b100000, lat);
        compared++;
        if ({res0, res1} !== {2{pk(1'b1, 5'd1, 6'b100000, 1'b0, 1'b0)}}) begin
            mismatched++;
            $display("FAIL emin: got %h/%h expected %h", res0, res1, pk(1'b1, 5'd1, 6'b100000, 1'b0, 1'b0));
        end
        drain();
        // e = 8+7-15 = 0: reserved, flushed.
        run_op(1'b0, 5'd8, 6'b100000, 1'b0, 5'd7, 6'b100000, lat);
        compared++;
        if ({res0, res1} !== {2{pk(1'b0, 5'd0, 6'b000000, 1'b0, 1'b1)}}) begin
            mismatched++;
            $display("FAIL ezero_unf: got %h/%h expected %h", res0, res1, pk(1'b0, 5'd0, 6'b000000, 1'b0, 1'b1));
        end
        drain();
    endtask

    task automatic test_zero();
        int lat;
        run_op(1'b0, 5'd15, 6'b000000, 1'b1, 5'd20, 6'b101000, lat);
        compared++;
        if (lat !== 7) begin
            mismatched++;
            $display("FAIL zero_latency: got %0d expected 7", lat);
        end
        compared++;
        if ({res0, res1} !== {2{pk(1'b1, 5'd0, 6'b000000, 1'b0, 1'b0)}}) begin
            mismatched++;
            $display("FAIL zero_result: got %h/%h expected %h", res0, res1, pk(1'b1, 5'd0, 6'b000000, 1'b0, 1'b0));
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [13:0] first_r, second_r;
        first_r  = pk(1'b1, 5'd16, 6'b100100, 1'b0, 1'b0);
        second_r = pk(1'b0, 5'd17, 6'b100000, 1'b0, 1'b0);
        @(negedge clk);
        out_ready = 1'b0;
        run_op(1'b0, 5'd15, 6'b110000, 1'b1, 5'd15, 6'b110000, lat);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            sign_a = 1'b0; exp_a = 5'd16; man_a = 6'b100000;
            sign_b = 1'b0; exp_b = 5'd16; man_b = 6'b100000;
            in_valid = 1'b1;
            @(posedge clk); #1;
            compared++;
            if ({out_valid0, in_ready0, res0} !== {1'b1, 1'b0, first_r}) begin
                mismatched++;
                $display("FAIL hold_cycle%0d: got %h expected %h", k, {out_valid0, in_ready0, res0}, {1'b1, 1'b0, first_r});
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        compared++;
        if ({out_valid0, in_ready0} !== 2'b01) begin
            mismatched++;
            $display("FAIL release_idle: got %b expected 01", {out_valid0, in_ready0});
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        compared++;
        if (in_ready0 !== 1'b0) begin
            mismatched++;
            $display("FAIL second_accept: got %b expected 0", in_ready0);
        end
        lat = 1;
        while (out_valid0 !== 1'b1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        compared++;
        if (lat !== 8) begin
            mismatched++;
            $display("FAIL second_latency: got %0d expected 8", lat);
        end
        compared++;
        if (res0 !== second_r) begin
            mismatched++;
            $display("FAIL second_result: got %h expected %h", res0, second_r);
        end
        drain();
    endtask

    task automatic test_reset_mid_op();
        int lat;
        @(negedge clk);
        sign_a = 1'b1; exp_a = 5'd20; man_a = 6'b111000;
        sign_b = 1'b0; exp_b = 5'd20; man_b = 6'b101010;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        compared++;
        if (in_ready0 !== 1'b0) begin
            mismatched++;
            $display("FAIL mid_busy: got %b expected 0", in_ready0);
        end
        rst_n = 1'b0;
        #1;
        compared++;
        if ({in_ready0, out_valid0, res0} !== {1'b1, 1'b0, 14'd0}) begin
            mismatched++;
            $display("FAIL mid_reset: got %h expected %h", {in_ready0, out_valid0, res0}, {1'b1, 1'b0, 14'd0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b0, 5'd16, 6'b110000, 1'b0, 5'd15, 6'b110000, lat);
        compared++;
        if ({lat[3:0], res0} !== {4'd7, pk(1'b0, 5'd17, 6'b100100, 1'b0, 1'b0)}) begin
            mismatched++;
            $display("FAIL after_reset: got %0d/%h expected 7/%h", lat, res0, pk(1'b0, 5'd17, 6'b100100, 1'b0, 1'b0));
        end
        drain();
    endtask

    initial begin
        #12;
        rst_n = 1'b1;
        test_reset();
        test_basic();
        test_rounding();
        test_ovf_unf();
        test_zero();
        test_back_to_back();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
